// File: rtl/case_1_acc_pkg.sv
// Shared types and default configuration for the case_1 product accumulator.
// Optional rounding is selected with CASE_1_ACC_ROUND_EN (see case_1_shift_sat).
package case_1_acc_pkg;

    localparam int DEF_DIN_WIDTH  = 13;
    localparam int DEF_FRAME_LEN  = 8;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_SHIFT      = 4;
    localparam int DEF_DOUT_WIDTH = 10;

    localparam int CNT_WIDTH = $clog2(DEF_FRAME_LEN);
    localparam int DOUT_MAX  = (2 ** (DEF_DOUT_WIDTH - 1)) - 1;
    localparam int DOUT_MIN  = -(2 ** (DEF_DOUT_WIDTH - 1));

    // Accumulator must hold FRAME_LEN worst-case products without wrapping.
    localparam bit ACC_WIDTH_OK = (DEF_ACC_WIDTH >= DEF_DIN_WIDTH + CNT_WIDTH);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

endpackage

// File: rtl/case_1_shift_sat.sv
// Combinational scale-and-clip of the frame sum: arithmetic right shift, optional
// round-half-up (CASE_1_ACC_ROUND_EN), then saturation to DOUT_WIDTH signed.
module case_1_shift_sat #(
    parameter int ACC_WIDTH  = 16,
    parameter int SHIFT      = 4,
    parameter int DOUT_WIDTH = 10
) (
    input  logic signed [ACC_WIDTH-1:0]  sum,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         sat
);

    // One guard bit so the rounding bias can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] MAXV = EW'((2 ** (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = EW'(-(2 ** (DOUT_WIDTH - 1)));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] sum_s;

    assign ext = EW'(sum);

`ifdef CASE_1_ACC_ROUND_EN
    generate
        if (SHIFT > 0) begin : g_round
            assign biased = ext + EW'(1 << (SHIFT - 1));
        end else begin : g_noround
            assign biased = ext;
        end
    endgenerate
`else
    assign biased = ext;
`endif

    assign sum_s = biased >>> SHIFT;

    always_comb begin
        dout = sum_s[DOUT_WIDTH-1:0];
        sat  = 1'b0;
        if (sum_s > MAXV) begin
            dout = MAXV[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (sum_s < MINV) begin
            dout = MINV[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/case_1_acc_sat_13s.sv
// Accumulates FRAME_LEN signed products, emits one scaled/saturated sum per frame.
// Latency: dout_vld one cycle after the last beat; input stalls (din_rdy=0) until dout handshakes.
// Rounding option: CASE_1_ACC_ROUND_EN.
module case_1_acc_sat_13s
    import case_1_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_vld,
    output logic                         din_rdy,
    input  logic                         frame_clr,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_vld,
    input  logic                         dout_rdy,
    output logic                         dout_sat
);

    localparam int CW = $clog2(FRAME_LEN);

    generate
        if (ACC_WIDTH < DIN_WIDTH + CW) begin : g_bad_acc_width
            $error("case_1_acc_sat_13s: ACC_WIDTH too small for FRAME_LEN products");
        end
    endgenerate

    state_t                        state, state_nxt;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic        [CW-1:0]          cnt;
    logic                          beat;
    logic                          last;
    logic signed [DOUT_WIDTH-1:0]  res;
    logic                          res_sat;

    // A clear wins over a coincident beat, which is dropped.
    assign beat    = din_vld && (state == S_ACC) && !frame_clr;
    assign last    = (cnt == CW'(FRAME_LEN - 1));
    assign acc_sum = acc + ACC_WIDTH'(din);

    case_1_shift_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_shift_sat (
        .sum  (acc_sum),
        .dout (res),
        .sat  (res_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din_rdy   = 1'b0;
        case (state)
            S_ACC: begin
                din_rdy = 1'b1;
                if (beat && last) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (dout_rdy) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sat <= 1'b0;
        end else if (state == S_ACC) begin
            if (frame_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (beat) begin
                if (last) begin
                    dout     <= res;
                    dout_sat <= res_sat;
                    dout_vld <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (dout_rdy) begin
            dout_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_case_1_acc_sat_13s.sv
// Directed-vector bench for case_1_acc_sat_13s; expected values are hand-computed
// for both builds (CASE_1_ACC_ROUND_EN defined or not).
module tb_case_1_acc_sat_13s;

    logic               ap_clk;
    logic               ap_rst_n;
    logic signed [12:0] din;
    logic               din_vld;
    logic               din_rdy;
    logic               frame_clr;
    logic signed [9:0]  dout;
    logic               dout_vld;
    logic               dout_rdy;
    logic               dout_sat;

    int nvec;
    int nmiss;

    case_1_acc_sat_13s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .frame_clr (frame_clr),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_sat  (dout_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmiss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Drive n consecutive beats of val; dout_vld must stay low until the last beat lands.
    task automatic beats(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            din     = 13'(val);
            din_vld = 1'b1;
            chk("rdy_in_frame", int'(din_rdy), 1);
            chk("vld_early", int'(dout_vld), 0);
            tick();
        end
        din_vld = 1'b0;
    endtask

    // Full frame with dout_rdy high: result one cycle after last beat, valid exactly one cycle.
    task automatic frame(input string tag, input int val, input int exp_d, input int exp_s);
        beats(val, 8);
        chk({tag, "_vld"}, int'(dout_vld), 1);
        chk({tag, "_dout"}, int'(dout), exp_d);
        chk({tag, "_sat"}, int'(dout_sat), exp_s);
        chk({tag, "_rdy_low"}, int'(din_rdy), 0);
        tick();
        chk({tag, "_vld_drop"}, int'(dout_vld), 0);
        chk({tag, "_rdy_back"}, int'(din_rdy), 1);
    endtask

    initial begin
        nvec      = 0;
        nmiss     = 0;
        ap_rst_n  = 1'b0;
        din       = '0;
        din_vld   = 1'b0;
        frame_clr = 1'b0;
        dout_rdy  = 1'b1;
        #2;
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(dout_vld), 0);
        chk("rst_sat", int'(dout_sat), 0);
        chk("rst_rdy", int'(din_rdy), 1);
        #20;
        ap_rst_n = 1'b1;
        tick();

        // 800 >>> 4 = 50
        frame("f100", 100, 50, 0);
        // 32760 >>> 4 = 2047 -> 511; -32768 >>> 4 = -2048 -> -512
        frame("fmax", 4095, 511, 1);
        frame("fmin", -4096, -512, 1);
`ifdef CASE_1_ACC_ROUND_EN
        frame("f3", 3, 2, 0);
        frame("fm1", -1, 0, 0);
`else
        frame("f3", 3, 1, 0);
        frame("fm1", -1, -1, 0);
`endif

        // Backpressure: result held 5 cycles, input blocked, frame_clr ignored.
        dout_rdy = 1'b0;
        beats(200, 8);
        din     = 13'(999);
        din_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame_clr = (i == 2);
            chk("bp_vld", int'(dout_vld), 1);
            chk("bp_dout", int'(dout), 100);
            chk("bp_sat", int'(dout_sat), 0);
            chk("bp_rdy", int'(din_rdy), 0);
            tick();
        end
        frame_clr = 1'b0;
        din_vld   = 1'b0;
        dout_rdy  = 1'b1;
        chk("bp_hold_final", int'(dout), 100);
        tick();
        chk("bp_vld_drop", int'(dout_vld), 0);
        // 56 >>> 4 = 3; rounded (56+8)>>>4 = 4. Any leaked held beat would change this.
`ifdef CASE_1_ACC_ROUND_EN
        frame("f7", 7, 4, 0);
`else
        frame("f7", 7, 3, 0);
`endif

        // Partial frame, then clear with a coincident beat, then a clean frame.
        beats(1000, 3);
        din       = 13'(1000);
        din_vld   = 1'b1;
        frame_clr = 1'b1;
        tick();
        chk("clr_rdy", int'(din_rdy), 1);
        frame_clr = 1'b0;
        din_vld   = 1'b0;
        frame("fclr", 16, 8, 0);

        // Asynchronous reset mid-frame.
        beats(500, 5);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mrst_dout", int'(dout), 0);
        chk("mrst_vld", int'(dout_vld), 0);
        chk("mrst_sat", int'(dout_sat), 0);
        chk("mrst_rdy", int'(din_rdy), 1);
        tick();
        ap_rst_n = 1'b1;
        tick();
        frame("frst", 32, 16, 0);

        // Asynchronous reset while a result is pending.
        dout_rdy = 1'b0;
        beats(4095, 8);
        chk("orst_pre_vld", int'(dout_vld), 1);
        ap_rst_n = 1'b0;
        #1;
        chk("orst_vld", int'(dout_vld), 0);
        chk("orst_dout", int'(dout), 0);
        chk("orst_sat", int'(dout_sat), 0);
        chk("orst_rdy", int'(din_rdy), 1);
        tick();
        ap_rst_n = 1'b1;
        dout_rdy = 1'b1;
        tick();
        frame("fpost", 100, 50, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
